jtag_cmd_sequencer: RTL and testbench



---
 rtl/jtag_pkg.sv | 18 +
 rtl/jtag_cmd_sequencer.sv | 160 ++++++++++++++++
 tb/tb_jtag_cmd_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared types and constants for the jtag command front-end and its neighbours.
package jtag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_IR,
    ST_LOAD_DR,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  localparam logic OP_IR = 1'b0;
  localparam logic OP_DR = 1'b1;

  localparam int DEFAULT_DR_WORDS = 4;

endpackage

// File: rtl/jtag_cmd_sequencer.sv
// Command front-end for the jtag shift engine: loads the IR/DR FIFO, pulses work,
// holds op for the whole transaction and reports done or a start timeout.
module jtag_cmd_sequencer
  import jtag_pkg::*;
#(
  parameter int DATA_INSTRUCTION = 10,
  parameter int DATA_FIFO        = 8,
  parameter int DR_WORDS         = DEFAULT_DR_WORDS,
  parameter int TIMEOUT          = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_op,
  input  logic [DATA_FIFO*DR_WORDS-1:0] cmd_payload,
  output logic                          done,
  output logic                          err,
  output logic                          op,
  output logic                          work,
  input  logic                          busy,
  output logic [DATA_INSTRUCTION-1:0]   wdata_instruction,
  output logic                          wr_instruction,
  input  logic                          full_instruction,
  output logic [DATA_FIFO-1:0]          wdata_data,
  output logic                          wr_data,
  input  logic                          full_data
);

  localparam int PW = DATA_FIFO * DR_WORDS;
  localparam int KW = (DR_WORDS > 1) ? $clog2(DR_WORDS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e                      state_q, state_d;
  logic                        cmd_op_q, cmd_op_d;
  logic [PW-1:0]               payload_q, payload_d;
  logic [KW-1:0]               k_q, k_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        op_q, op_d;
  logic                        work_q, work_d;
  logic                        wr_instruction_q, wr_instruction_d;
  logic                        wr_data_q, wr_data_d;
  logic [DATA_INSTRUCTION-1:0] wdata_instruction_q, wdata_instruction_d;
  logic [DATA_FIFO-1:0]        wdata_data_q, wdata_data_d;

  assign cmd_ready = (state_q == ST_IDLE) && !busy;

  always_comb begin
    state_d             = state_q;
    cmd_op_d            = cmd_op_q;
    payload_d           = payload_q;
    k_d                 = k_q;
    cnt_d               = cnt_q;
    op_d                = op_q;
    wdata_instruction_d = wdata_instruction_q;
    wdata_data_d        = wdata_data_q;
    done_d              = 1'b0;
    err_d               = 1'b0;
    work_d              = 1'b0;
    wr_instruction_d    = 1'b0;
    wr_data_d           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_op_d  = cmd_op;
          payload_d = cmd_payload;
          k_d       = '0;
          state_d   = (cmd_op == OP_DR) ? ST_LOAD_DR : ST_LOAD_IR;
        end
      end
      ST_LOAD_IR: begin
        if (!full_instruction) begin
          wr_instruction_d    = 1'b1;
          wdata_instruction_d = payload_q[DATA_INSTRUCTION-1:0];
          state_d             = ST_START;
        end
      end
      // Least significant byte first so payload bit 0 is the first bit shifted out.
      ST_LOAD_DR: begin
        if (!full_data) begin
          wr_data_d    = 1'b1;
          wdata_data_d = payload_q[DATA_FIFO*k_q +: DATA_FIFO];
          k_d          = k_q + KW'(1);
          if (k_q == KW'(DR_WORDS - 1)) begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        op_d    = cmd_op_q;
        work_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          err_d   = 1'b1;
          op_d    = OP_IR;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy) begin
          done_d  = 1'b1;
          op_d    = OP_IR;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= ST_IDLE;
      cmd_op_q            <= OP_IR;
      payload_q           <= '0;
      k_q                 <= '0;
      cnt_q               <= '0;
      done_q              <= 1'b0;
      err_q               <= 1'b0;
      op_q                <= OP_IR;
      work_q              <= 1'b0;
      wr_instruction_q    <= 1'b0;
      wr_data_q           <= 1'b0;
      wdata_instruction_q <= '0;
      wdata_data_q        <= '0;
    end else begin
      state_q             <= state_d;
      cmd_op_q            <= cmd_op_d;
      payload_q           <= payload_d;
      k_q                 <= k_d;
      cnt_q               <= cnt_d;
      done_q              <= done_d;
      err_q               <= err_d;
      op_q                <= op_d;
      work_q              <= work_d;
      wr_instruction_q    <= wr_instruction_d;
      wr_data_q           <= wr_data_d;
      wdata_instruction_q <= wdata_instruction_d;
      wdata_data_q        <= wdata_data_d;
    end
  end

  assign done              = done_q;
  assign err               = err_q;
  assign op                = op_q;
  assign work              = work_q;
  assign wr_instruction    = wr_instruction_q;
  assign wr_data           = wr_data_q;
  assign wdata_instruction = wdata_instruction_q;
  assign wdata_data        = wdata_data_q;

endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// Randomized bench for jtag_cmd_sequencer: a transaction-level model predicts FIFO
// writes, the work pulse and the done/err cycle from per-cycle full schedules.
module tb_jtag_cmd_sequencer;

  localparam int DI     = 10;
  localparam int DF     = 8;
  localparam int DRW    = 4;
  localparam int TMO    = 8;
  localparam int PW     = DF * DRW;
  localparam int SCHED  = 64;
  localparam int BUDGET = 150;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [PW-1:0] cmd_payload;
  logic          done;
  logic          err;
  logic          op;
  logic          work;
  logic          busy;
  logic [DI-1:0] wdata_instruction;
  logic          wr_instruction;
  logic          full_instruction;
  logic [DF-1:0] wdata_data;
  logic          wr_data;
  logic          full_data;

  int checks = 0;
  int errors = 0;

  bit fullDataSched[SCHED];
  bit fullInstrSched[SCHED];

  jtag_cmd_sequencer #(
    .DATA_INSTRUCTION(DI),
    .DATA_FIFO(DF),
    .DR_WORDS(DRW),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_payload(cmd_payload),
    .done(done),
    .err(err),
    .op(op),
    .work(work),
    .busy(busy),
    .wdata_instruction(wdata_instruction),
    .wr_instruction(wr_instruction),
    .full_instruction(full_instruction),
    .wdata_data(wdata_data),
    .wr_data(wr_data),
    .full_data(full_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearSchedule();
    for (int i = 0; i < SCHED; i++) begin
      fullDataSched[i]  = 1'b0;
      fullInstrSched[i] = 1'b0;
    end
  endtask

  task automatic checkResetValues(input string prefix);
    checkOutput({prefix, "_done"}, 32'(done), 32'd0);
    checkOutput({prefix, "_err"}, 32'(err), 32'd0);
    checkOutput({prefix, "_op"}, 32'(op), 32'd0);
    checkOutput({prefix, "_work"}, 32'(work), 32'd0);
    checkOutput({prefix, "_wr_instruction"}, 32'(wr_instruction), 32'd0);
    checkOutput({prefix, "_wr_data"}, 32'(wr_data), 32'd0);
    checkOutput({prefix, "_wdata_instruction"}, 32'(wdata_instruction), 32'd0);
    checkOutput({prefix, "_wdata_data"}, 32'(wdata_data), 32'd0);
  endtask

  // One full command. Relative cycle 0 is the cycle right after the accepting edge;
  // the engine model raises busy busyDelay cycles after it sees work, or never when
  // busyDelay would land at or beyond the timeout.
  task automatic applyStimulus(input logic opIn, input logic [PW-1:0] payloadIn, input int preBusy,
                               input int busyDelay, input int busyLen);
    int          expCyc[$];
    logic [31:0] expDat[$];
    int          obsCyc[$];
    logic [31:0] obsDat[$];
    bit          noBusy = (busyDelay >= TMO);
    int          c = 0;
    int          k = 0;
    int          waitCnt = 0;
    int          expWork;
    int          expEnd;
    int          busyRise = -1;
    int          busyFall = -1;
    int          otherWrites = 0;
    int          workCount = 0;
    int          workCycle = -1;
    logic        workOp = 1'b0;
    int          doneCount = 0;
    int          errCount = 0;
    int          doneCycle = -1;
    int          errCycle = -1;
    int          opViol = 0;
    bit          finished = 1'b0;

    if (opIn) begin
      while (k < DRW) begin
        if (!fullDataSched[c]) begin
          expCyc.push_back(c + 1);
          expDat.push_back((32'(payloadIn) >> (DF * k)) & 32'hFF);
          k++;
        end
        c++;
      end
    end else begin
      while (fullInstrSched[c]) c++;
      expCyc.push_back(c + 1);
      expDat.push_back(32'(payloadIn[DI-1:0]));
      c++;
    end
    expWork = c + 1;
    expEnd  = noBusy ? expWork + TMO : expWork + busyDelay + busyLen + 1;

    for (int i = 0; i < preBusy; i++) begin
      @(posedge clk); #1;
      busy = 1'b1; cmd_valid = 1'b1; cmd_op = opIn; cmd_payload = payloadIn;
      full_data = 1'b0; full_instruction = 1'b0;
      @(negedge clk);
      checkOutput("ready_blocked_by_busy", 32'(cmd_ready), 32'd0);
      checkOutput("no_write_while_blocked", 32'({wr_instruction, wr_data}), 32'd0);
    end

    @(posedge clk); #1;
    busy = 1'b0; cmd_valid = 1'b1; cmd_op = opIn; cmd_payload = payloadIn;
    full_data = 1'b0; full_instruction = 1'b0;
    @(negedge clk);
    checkOutput("ready_when_idle", 32'(cmd_ready), 32'd1);
    while (!cmd_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end

    for (int rel = 0; rel < BUDGET && !finished; rel++) begin
      @(posedge clk); #1;
      cmd_valid        = 1'b0;
      full_data        = fullDataSched[rel % SCHED] && (rel < SCHED);
      full_instruction = fullInstrSched[rel % SCHED] && (rel < SCHED);
      busy             = (busyRise >= 0) && (rel >= busyRise) && (rel < busyFall);
      @(negedge clk);
      if (wr_instruction) begin
        if (!opIn) begin obsCyc.push_back(rel); obsDat.push_back(32'(wdata_instruction)); end
        else otherWrites++;
      end
      if (wr_data) begin
        if (opIn) begin obsCyc.push_back(rel); obsDat.push_back(32'(wdata_data)); end
        else otherWrites++;
      end
      if (work) begin
        workCount++;
        if (workCount == 1) begin
          workCycle = rel;
          workOp    = op;
          if (!noBusy) begin
            busyRise = rel + busyDelay;
            busyFall = busyRise + busyLen;
          end
        end
      end
      if (workCount > 0 && !done && !err && (noBusy || rel < busyFall) && op !== opIn) opViol++;
      if (done) begin doneCount++; if (doneCycle < 0) doneCycle = rel; finished = 1'b1; end
      if (err) begin errCount++; if (errCycle < 0) errCycle = rel; finished = 1'b1; end
    end
    if (!finished) checkOutput("end_within_budget", 32'd0, 32'd1);

    @(posedge clk); #1;
    busy = 1'b0; full_data = 1'b0; full_instruction = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_end", 32'(cmd_ready), 32'd1);
    checkOutput("op_cleared_after_end", 32'(op), 32'd0);
    checkOutput("pulse_single_cycle", 32'({done, err}), 32'd0);

    checkOutput("write_count", 32'(obsCyc.size()), 32'(expCyc.size()));
    for (int i = 0; i < expCyc.size() && i < obsCyc.size(); i++) begin
      checkOutput("write_data", obsDat[i], expDat[i]);
      checkOutput("write_cycle", 32'(obsCyc[i]), 32'(expCyc[i]));
    end
    checkOutput("wrong_fifo_writes", 32'(otherWrites), 32'd0);
    checkOutput("work_count", 32'(workCount), 32'd1);
    checkOutput("work_cycle", 32'(workCycle), 32'(expWork));
    checkOutput("work_op", 32'(workOp), 32'(opIn));
    checkOutput("op_held", 32'(opViol), 32'd0);
    if (noBusy) begin
      checkOutput("err_cycle", 32'(errCycle), 32'(expEnd));
      checkOutput("err_count", 32'(errCount), 32'd1);
      checkOutput("no_done_on_timeout", 32'(doneCount), 32'd0);
    end else begin
      checkOutput("done_cycle", 32'(doneCycle), 32'(expEnd));
      checkOutput("done_count", 32'(doneCount), 32'd1);
      checkOutput("no_err_on_done", 32'(errCount), 32'd0);
    end
  endtask

  task automatic resetDuringWaitDone();
    int waitCnt = 0;
    int doneSeen = 0;
    bit workSeen = 1'b0;

    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_payload = 32'h155;
    busy = 1'b0; full_data = 1'b0; full_instruction = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (!workSeen && waitCnt < 20) begin
      @(negedge clk);
      if (work) workSeen = 1'b1;
      else begin @(posedge clk); #1; waitCnt++; end
    end
    checkOutput("reset_test_work_seen", 32'(workSeen), 32'd1);

    @(posedge clk); #1; busy = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; busy = 1'b0;
    @(negedge clk);
    checkResetValues("mid_reset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("no_done_after_reset", 32'(doneSeen), 32'd0);
    checkOutput("ready_after_mid_reset", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_payload = '0;
    busy = 1'b0; full_data = 1'b0; full_instruction = 1'b0;
    clearSchedule();

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("after_reset");
    checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);

    applyStimulus(1'b0, 32'h2A5, 0, 2, 3);
    applyStimulus(1'b1, 32'hDEADBEEF, 0, 3, 4);

    clearSchedule();
    fullDataSched[2] = 1'b1; fullDataSched[3] = 1'b1; fullDataSched[4] = 1'b1;
    applyStimulus(1'b1, 32'hDEADBEEF, 0, 1, 2);
    clearSchedule();

    applyStimulus(1'b0, 32'h3C3, 0, TMO + 5, 1);

    resetDuringWaitDone();
    applyStimulus(1'b1, 32'h12345678, 0, 1, 1);

    applyStimulus(1'b0, 32'h0F0, 3, 2, 2);

    for (int n = 0; n < 20; n++) begin
      clearSchedule();
      for (int i = 0; i < 16; i++) begin
        fullDataSched[i]  = ($urandom_range(3) == 0);
        fullInstrSched[i] = ($urandom_range(3) == 0);
      end
      applyStimulus(1'($urandom_range(1)), $urandom, int'($urandom_range(2)),
                    int'($urandom_range(TMO + 2, 1)), int'($urandom_range(6, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
